// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst read/write master for a synchronous single-port word memory
// Optional feature macro: MEM_BURST_BOUND_CHECK_EN (reject bursts that would run past the top address)
module mem_burst_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic              mem_write_readBar_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_data_out_o,
    input  logic [DATA_W-1:0] mem_data_in_i
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   last_addr_q;
    logic                done_q, done_d;
    logic                rd_pend_q, rd_last_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_issue;
    logic                oob;
    logic                err_d;

`ifdef MEM_BURST_BOUND_CHECK_EN
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    logic [SUM_W-1:0] end_addr;
    logic             err_q;

    assign end_addr = SUM_W'(base_addr_i) + SUM_W'(length_i);
    assign oob      = end_addr > (SUM_W'(1) << ADDR_W);
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign oob   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        count_d             = count_q;
        // The final read word leaves the pipeline while DRAIN is active
        done_d              = rd_last_q;
        err_d               = 1'b0;
        rd_issue            = 1'b0;
        wr_ready_o          = 1'b0;
        mem_write_readBar_o = 1'b0;
        mem_address_o       = last_addr_q;
        mem_data_out_o      = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else if (oob) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = base_addr_i;
                        count_d = length_i;
                        state_d = cmd_write_i ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                mem_address_o = addr_q;
                rd_issue      = 1'b1;
                addr_d        = addr_q + 1'b1;
                count_d       = count_q - 1'b1;
                if (count_q == LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_last_q) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                wr_ready_o          = 1'b1;
                mem_write_readBar_o = wr_valid_i;
                mem_address_o       = addr_q;
                mem_data_out_o      = wr_data_i;
                if (wr_valid_i) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            last_addr_q <= '0;
            done_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            last_addr_q <= mem_address_o;
            done_q      <= done_d;
            // Memory returns data one cycle after the address; register it once more
            rd_pend_q   <= rd_issue;
            rd_last_q   <= rd_issue && (count_q == LEN_W'(1));
            rd_valid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= mem_data_in_i;
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - directed scoreboard bench for mem_burst_master
module tb_mem_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cmd_write;
    logic [9:0]  base;
    logic [9:0]  length;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        mem_we;
    logic [9:0]  mem_address;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;

    logic [31:0] mem [0:1023];
    logic [31:0] sb [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cyc;
    int n_rv, n_done, n_err, n_wr, n_busy;
    int first_rv, last_rv, done_cyc, err_cyc, last_wr_cyc;
    int done_sb;
    logic done_rv;
    logic [9:0] addr_prev;

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .start_i             (start),
        .cmd_write_i         (cmd_write),
        .base_addr_i         (base),
        .length_i            (length),
        .busy_o              (busy),
        .done_o              (done),
        .err_o               (err),
        .rd_data_o           (rd_data),
        .rd_valid_o          (rd_valid),
        .wr_data_i           (wr_data),
        .wr_valid_i          (wr_valid),
        .wr_ready_o          (wr_ready),
        .mem_write_readBar_o (mem_we),
        .mem_address_o       (mem_address),
        .mem_data_out_o      (mem_dout),
        .mem_data_in_i       (mem_din)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_dout;
        mem_din <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_rv = 0; n_done = 0; n_err = 0; n_wr = 0; n_busy = 0;
        first_rv = -1; last_rv = -1; done_cyc = -1; err_cyc = -1; last_wr_cyc = -1;
        done_sb = -1; done_rv = 1'b0;
        sb.delete();
    endtask

    task automatic sample();
        logic [31:0] e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_extra_word", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e));
            end
            n_rv++;
            if (first_rv < 0) first_rv = cyc;
            last_rv = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_rv  = rd_valid;
            done_sb  = sb.size();
        end
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (mem_we) begin
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (busy) n_busy++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_start(input logic w, input logic [9:0] b, input logic [9:0] l);
        cmd_write = w;
        base      = b;
        length    = l;
        start     = 1'b1;
        s_cyc     = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (n_done == 0 && n_err == 0 && k < limit) begin
            tick();
            k++;
        end
        chk("timeout_done_or_err", 64'((n_done + n_err) > 0), 64'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cmd_write = 1'b0; base = '0; length = '0;
        wr_data = '0; wr_valid = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        reset = 1'b1;
        tick();

        // Basic read burst
        clear_stats();
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        sb.push_back(32'h11); sb.push_back(32'h22); sb.push_back(32'h33); sb.push_back(32'h44);
        drive_start(1'b0, 10'd0, 10'd4);
        wait_done(20);
        repeat (2) tick();
        chk("rdA_first_rv", 64'(first_rv), 64'(s_cyc + 3));
        chk("rdA_last_rv", 64'(last_rv), 64'(s_cyc + 6));
        chk("rdA_count", 64'(n_rv), 64'd4);
        chk("rdA_done_cyc", 64'(done_cyc), 64'(s_cyc + 6));
        chk("rdA_done_with_rv", 64'(done_rv), 64'd1);
        chk("rdA_done_last_word", 64'(done_sb), 64'd0);
        chk("rdA_done_count", 64'(n_done), 64'd1);

        // Write burst with a one-cycle wr_valid gap
        clear_stats();
        drive_start(1'b1, 10'h100, 10'd3);
        wr_valid = 1'b1; wr_data = 32'hA;
        #1;
        chk("wr_ready", 64'(wr_ready), 64'd1);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_addr", 64'(mem_address), 64'h100);
        chk("wr_mem_dout", 64'(mem_dout), 64'hA);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("wr_gap_no_write", 64'(mem_we), 64'd0);
        tick();
        wr_valid = 1'b1; wr_data = 32'hB;
        tick();
        wr_data = 32'hC;
        tick();
        wr_valid = 1'b0;
        wait_done(5);
        tick();
        chk("wr_count", 64'(n_wr), 64'd3);
        chk("wr_last_cyc", 64'(last_wr_cyc), 64'(s_cyc + 4));
        chk("wr_done_cyc", 64'(done_cyc), 64'(s_cyc + 5));
        clear_stats();
        sb.push_back(32'hA); sb.push_back(32'hB); sb.push_back(32'hC);
        drive_start(1'b0, 10'h100, 10'd3);
        wait_done(20);
        repeat (2) tick();
        chk("rb_count", 64'(n_rv), 64'd3);
        chk("rb_sb_empty", 64'(sb.size()), 64'd0);

        // Burst crossing the top of the address space
        clear_stats();
        mem[1022] = 32'hD1; mem[1023] = 32'hD2; mem[0] = 32'hD3; mem[1] = 32'hD4;
        addr_prev = mem_address;
`ifdef MEM_BURST_BOUND_CHECK_EN
        drive_start(1'b0, 10'd1022, 10'd4);
        wait_done(6);
        repeat (4) tick();
        chk("oob_err_count", 64'(n_err), 64'd1);
        chk("oob_err_cyc", 64'(err_cyc), 64'(s_cyc + 1));
        chk("oob_busy", 64'(n_busy), 64'd0);
        chk("oob_no_read", 64'(n_rv), 64'd0);
        chk("oob_no_done", 64'(n_done), 64'd0);
        chk("oob_addr_hold", 64'(mem_address), 64'(addr_prev));
`else
        sb.push_back(32'hD1); sb.push_back(32'hD2); sb.push_back(32'hD3); sb.push_back(32'hD4);
        drive_start(1'b0, 10'd1022, 10'd4);
        wait_done(20);
        repeat (2) tick();
        chk("wrap_count", 64'(n_rv), 64'd4);
        chk("wrap_no_err", 64'(n_err), 64'd0);
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);
`endif

        // Zero-length command
        clear_stats();
        addr_prev = mem_address;
        drive_start(1'b0, 10'h055, 10'd0);
        wait_done(4);
        repeat (4) tick();
        chk("len0_done_cyc", 64'(done_cyc), 64'(s_cyc + 1));
        chk("len0_no_rv", 64'(n_rv), 64'd0);
        chk("len0_addr_hold", 64'(mem_address), 64'(addr_prev));
        chk("len0_no_busy", 64'(n_busy), 64'd0);

        // Reset in the middle of a write burst
        clear_stats();
        drive_start(1'b1, 10'h200, 10'd5);
        wr_valid = 1'b1; wr_data = 32'h50;
        tick();
        wr_data = 32'h51;
        #1;
        reset = 1'b0;
        #1;
        chk("rstmid_mem_we", 64'(mem_we), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_wr_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rstmid_no_done", 64'(n_done), 64'd0);
        chk("rstmid_word1", 64'(mem[10'h200]), 64'h50);
        chk("rstmid_word2_not_written", 64'(mem[10'h201]), 64'h0);
        clear_stats();
        sb.push_back(32'h50); sb.push_back(32'h0);
        drive_start(1'b0, 10'h200, 10'd2);
        wait_done(20);
        repeat (2) tick();
        chk("post_rst_count", 64'(n_rv), 64'd2);
        chk("post_rst_done", 64'(n_done), 64'd1);

        // start while busy is ignored
        clear_stats();
        mem[10'h300] = 32'h61; mem[10'h301] = 32'h62; mem[10'h302] = 32'h63; mem[10'h303] = 32'h64;
        sb.push_back(32'h61); sb.push_back(32'h62); sb.push_back(32'h63); sb.push_back(32'h64);
        drive_start(1'b0, 10'h300, 10'd4);
        tick();
        start = 1'b1; cmd_write = 1'b1; base = 10'h010; length = 10'd2;
        tick();
        start = 1'b0; cmd_write = 1'b0;
        wait_done(20);
        repeat (3) tick();
        chk("busy_start_count", 64'(n_rv), 64'd4);
        chk("busy_start_first_rv", 64'(first_rv), 64'(s_cyc + 3));
        chk("busy_start_done", 64'(n_done), 64'd1);
        chk("busy_start_no_write", 64'(n_wr), 64'd0);
        chk("busy_start_no_err", 64'(n_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
